// File: rtl/uart_rx_frame_fifo.sv
// UART receive framer: a one-byte staging register feeds a show-ahead FIFO.
// The byte in staging is pushed with tlast=0 when the next byte arrives, or
// with tlast=1 once the line has been idle for GAP_CLKS clocks.
module uart_rx_frame_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned GAP_CLKS = 160
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_s_axis_tvalid,
  input  logic [7:0]               i_s_axis_tdata,
  input  logic                     i_rxd_busy,
  output logic                     o_m_axis_tvalid,
  output logic [7:0]               o_m_axis_tdata,
  output logic                     o_m_axis_tlast,
  input  logic                     i_m_axis_tready,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned GapW = $clog2(GAP_CLKS);

  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CLKS - 1);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   FillOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   FillMax = (PtrW + 1)'(DEPTH);

  // Staging and gap counter state.
  logic            stg_valid_q;
  logic [7:0]      stg_data_q;
  logic [GapW-1:0] gap_q;

  // FIFO state; each entry is {tlast, data}.
  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   fill_q;
  logic            overflow_q;

  logic            gap_inc;
  logic            close;
  logic            push;
  logic [8:0]      push_entry;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop;

  // Decode push/pop for this cycle; an input beat pre-empts a frame close.
  always_comb begin
    gap_inc    = stg_valid_q & ~i_rxd_busy & ~i_s_axis_tvalid;
    close      = gap_inc & (gap_q == GapLast);
    push       = (i_s_axis_tvalid & stg_valid_q) | close;
    // close is only possible without an input beat, so tlast follows it directly.
    push_entry = {close, stg_data_q};
    pop        = (fill_q != '0) & i_m_axis_tready;
    full       = (fill_q == FillMax);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en      = push & (~full | pop);
    drop       = push & full & ~pop;
  end

  // Staging register and idle-gap counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= 8'h00;
      gap_q       <= '0;
    end else begin
      if (i_s_axis_tvalid) begin
        stg_valid_q <= 1'b1;
        stg_data_q  <= i_s_axis_tdata;
        gap_q       <= '0;
      end else if (i_rxd_busy) begin
        gap_q <= '0;
      end else if (close) begin
        stg_valid_q <= 1'b0;
        gap_q       <= '0;
      end else if (gap_inc) begin
        gap_q <= gap_q + GapOne;
      end
    end
  end

  // FIFO storage; contents need no reset because fill gates visibility.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (wr_en && !pop) begin
        fill_q <= fill_q + FillOne;
      end else if (!wr_en && pop) begin
        fill_q <= fill_q - FillOne;
      end
      // Set wins over clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (i_clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Show-ahead outputs, forced to zero while empty so reset presents 0x00.
  always_comb begin
    o_m_axis_tvalid = (fill_q != '0);
    {o_m_axis_tlast, o_m_axis_tdata} = o_m_axis_tvalid ? mem_q[rd_ptr_q] : 9'h000;
    o_fill          = fill_q;
    o_overflow      = overflow_q;
  end

endmodule

// File: doc/uart_rx_frame_fifo.md
UART_RX_FRAME_FIFO -- requirements
Module: uart_rx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of FIFO entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter GAP_CLKS, default 160, the number of idle clocks after the last byte that closes a frame; must be at least 2.
REQ-003 i_clk  input  1  single clock; all logic is on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_s_axis_tvalid  input  1  one-cycle byte strobe from the UART receiver; there is no tready (no backpressure).
REQ-006 i_s_axis_tdata  input  8  received byte, qualified by i_s_axis_tvalid.
REQ-007 i_rxd_busy  input  1  receiver busy: high while a character is in progress.
REQ-008 o_m_axis_tvalid  output  1  output byte available.
REQ-009 o_m_axis_tdata  output  8  output byte.
REQ-010 o_m_axis_tlast  output  1  marks the final byte of a frame.
REQ-011 i_m_axis_tready  input  1  downstream ready.
REQ-012 o_fill  output  $clog2(DEPTH)+1  number of FIFO entries occupied; the staging register is excluded.
REQ-013 o_overflow  output  1  sticky flag: a byte was dropped.
REQ-014 i_clr_overflow  input  1  synchronous clear of o_overflow.

Function
REQ-015 SHALL hold the newest received byte in a one-entry staging register (stg_valid, stg_data) ahead of the FIFO.
REQ-016 On i_s_axis_tvalid=1 with stg_valid=1, SHALL push {stg_data, tlast=0}, load the new byte into staging and clear the gap counter, all in the same cycle.
REQ-017 On i_s_axis_tvalid=1 with stg_valid=0, SHALL load staging, set stg_valid=1 and clear the gap counter, with no push.
REQ-018 The gap counter SHALL increment only in cycles where stg_valid=1, i_rxd_busy=0 and i_s_axis_tvalid=0.
REQ-019 The gap counter SHALL clear to 0 whenever i_rxd_busy=1.
REQ-020 When the gap counter equals GAP_CLKS-1 and the increment condition holds, SHALL push {stg_data, tlast=1}, clear stg_valid and clear the counter.
REQ-021 An input beat SHALL take priority over frame close, so a byte is never pushed twice.
REQ-022 The FIFO SHALL be show-ahead: o_m_axis_tvalid=1 whenever fill>0, with o_m_axis_tdata/tlast presenting the entry at the read pointer.
REQ-023 A pushed entry SHALL be visible at the output on the cycle after the push (one-cycle latency).
REQ-024 A pop SHALL occur on a cycle with o_m_axis_tvalid=1 and i_m_axis_tready=1; the read pointer advances and the next entry appears on the following cycle.
REQ-025 Outputs SHALL remain stable while o_m_axis_tvalid=1 and i_m_axis_tready=0.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 On simultaneous push and pop, o_fill SHALL be unchanged; when full, the push is accepted because the pop frees an entry.
REQ-028 A push when fill=DEPTH and no pop SHALL drop the entry, leave the FIFO unchanged and set o_overflow; staging updates normally.
REQ-029 When o_overflow is set and i_clr_overflow=1 in the same cycle, set SHALL win.
REQ-030 A pop with fill=0 SHALL be impossible; i_m_axis_tready is ignored while o_m_axis_tvalid=0.
REQ-031 o_m_axis_tdata/tlast are don't-care while o_m_axis_tvalid=0.

Reset
REQ-032 While i_rst_n=0, asynchronously: pointers=0, o_fill=0, stg_valid=0, gap counter=0, o_overflow=0, o_m_axis_tvalid=0, o_m_axis_tdata=0x00, o_m_axis_tlast=0.
REQ-033 Reset mid-frame SHALL discard staging and all FIFO contents, and no tlast is emitted for the discarded frame.
REQ-034 Deassertion SHALL be synchronised to i_clk, and the block SHALL accept an input beat on the first cycle after deassertion.

Verification
REQ-035 Single byte: beat 0x41, busy low, tready=1 -> after GAP_CLKS idle cycles, one output beat 0x41 with tlast=1; o_fill returns to 0.
REQ-036 Three-byte frame: beats 0x01, 0x02, 0x03 spaced 160 clocks with busy high between them -> outputs 0x01/tlast=0, 0x02/tlast=0, 0x03/tlast=1; 0x03 appears only after the gap expires.
REQ-037 Gap reset: busy held low for GAP_CLKS-2 clocks, then high for 1 clock, then low -> no frame close until a full GAP_CLKS of idle has elapsed.
REQ-038 Overflow: tready=0, DEPTH+2 beats followed by the gap -> o_fill=DEPTH and o_overflow=1; draining yields the first DEPTH bytes in order with no tlast.
REQ-039 Full with simultaneous push/pop: fill=DEPTH, tready=1 in the cycle a push occurs -> o_fill stays DEPTH and o_overflow stays 0.
REQ-040 Reset mid-operation: fill=5 with staging valid, pulse i_rst_n low for 1 clock -> all outputs 0 immediately, and no output beats afterwards without new input.
